// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC holder, icache fetch, RV32IC predecode and fetch output queue
module fetch_unit #(
  parameter int          FOQ_SIZE   = 8,
  parameter int          FOQ_SIZE_W = 3,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  output logic        branch,
  output logic [31:0] imm,
  output logic        inst_length,
  output logic [31:0] pc_out,
  output logic        foq_full,
  input  logic        need_branch,
  input  logic [31:0] branch_addr,
  input  logic        predict_fail,
  input  logic [31:0] fail_addr,
  input  logic        jalr_done,
  input  logic [31:0] jalr_addr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_pred,
  output logic        dec_len
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_JALR_WAIT, S_DROP} state_t;

  localparam logic [FOQ_SIZE_W:0] FOQ_CAP = (FOQ_SIZE_W + 1)'(FOQ_SIZE);

  state_t                state, state_nx;
  logic [31:0]           pc, pc_nx;

  logic [31:0]           foq_inst [FOQ_SIZE];
  logic [31:0]           foq_pc   [FOQ_SIZE];
  logic                  foq_pred [FOQ_SIZE];
  logic                  foq_len  [FOQ_SIZE];
  logic [FOQ_SIZE_W-1:0] front, rear;
  logic [FOQ_SIZE_W:0]   count;

  logic        active, accept, push, pop;
  logic        is_32, is_br, is_jal, is_jalr;
  logic [31:0] imm_raw, inst_masked;

  // Frozen or in reset: nothing moves and nothing is requested.
  assign active   = rst_in && rdy_in;
  assign foq_full = (count == FOQ_CAP);
  assign accept   = active && (state == S_WAIT) && icache_valid && !predict_fail && !foq_full;
  assign push     = accept;
  assign pop      = active && !predict_fail && dec_valid && dec_ready;

  assign icache_addr = pc;
  assign inst_masked = is_32 ? icache_data : {16'h0, icache_data[15:0]};

  // Predecode the returned word into control-flow class and offset.
  always_comb begin
    logic [1:0] q;
    logic [2:0] f3;
    logic [6:0] op;
    q       = icache_data[1:0];
    f3      = icache_data[15:13];
    op      = icache_data[6:0];
    is_32   = (q == 2'b11);
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    imm_raw = 32'h0;
    if (is_32 && op == 7'b1100011) begin
      is_br   = 1'b1;
      imm_raw = {{20{icache_data[31]}}, icache_data[7], icache_data[30:25], icache_data[11:8], 1'b0};
    end else if (q == 2'b01 && (f3 == 3'b110 || f3 == 3'b111)) begin
      is_br   = 1'b1;
      imm_raw = {{24{icache_data[12]}}, icache_data[6:5], icache_data[2], icache_data[11:10],
                 icache_data[4:3], 1'b0};
    end else if (is_32 && op == 7'b1101111) begin
      is_jal  = 1'b1;
      imm_raw = {{12{icache_data[31]}}, icache_data[19:12], icache_data[20], icache_data[30:21], 1'b0};
    end else if (q == 2'b01 && (f3 == 3'b101 || f3 == 3'b001)) begin
      is_jal  = 1'b1;
      imm_raw = {{21{icache_data[12]}}, icache_data[8], icache_data[10:9], icache_data[6],
                 icache_data[7], icache_data[2], icache_data[11], icache_data[5:3], 1'b0};
    end else if (is_32 && op == 7'b1100111) begin
      is_jalr = 1'b1;
    end else if (q == 2'b10 && f3 == 3'b100 && icache_data[11:7] != 5'd0 && icache_data[6:2] == 5'd0) begin
      is_jalr = 1'b1;
    end
  end

  // State register; frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (!rst_in)     state <= S_FETCH;
    else if (rdy_in) state <= state_nx;
  end

  // Next state and next PC; a mispredict overrides every other source.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (predict_fail) begin
      pc_nx    = fail_addr;
      state_nx = (state == S_WAIT && !icache_valid) ? S_DROP : S_FETCH;
    end else begin
      case (state)
        S_FETCH:     if (!foq_full) state_nx = S_WAIT;
        S_WAIT: begin
          if (accept) begin
            state_nx = S_FETCH;
            if (branch)       pc_nx = branch_addr;
            else if (is_jal)  pc_nx = pc + imm_raw;
            else if (is_jalr) state_nx = S_JALR_WAIT;
            else              pc_nx = pc + (is_32 ? 32'd4 : 32'd2);
          end
        end
        S_JALR_WAIT: begin
          if (jalr_done) begin
            pc_nx    = jalr_addr;
            state_nx = S_FETCH;
          end
        end
        S_DROP:      if (icache_valid) state_nx = S_FETCH;
        default:     state_nx = S_FETCH;
      endcase
    end
  end

  // FSM outputs: request and predictor-facing predecode, all quiet unless a response is taken.
  always_comb begin
    icache_req  = active && ((state == S_FETCH && !foq_full) || state == S_WAIT);
    branch      = accept && is_br;
    imm         = accept ? imm_raw : 32'h0;
    inst_length = accept && is_32;
    pc_out      = accept ? pc : 32'h0;
  end

  // PC register.
  always_ff @(posedge clk_in) begin
    if (!rst_in)     pc <= RESET_PC;
    else if (rdy_in) pc <= pc_nx;
  end

  // Fetch output queue: circular buffer, flushed on mispredict.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
      for (int i = 0; i < FOQ_SIZE; i++) begin
        foq_inst[i] <= 32'h0;
        foq_pc[i]   <= 32'h0;
        foq_pred[i] <= 1'b0;
        foq_len[i]  <= 1'b0;
      end
    end else if (rdy_in) begin
      if (predict_fail) begin
        front <= '0;
        rear  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          foq_inst[rear] <= inst_masked;
          foq_pc[rear]   <= pc;
          foq_pred[rear] <= need_branch && branch;
          foq_len[rear]  <= is_32;
          rear           <= rear + 1'b1;
        end
        if (pop) front <= front + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  assign dec_valid = (count != '0);
  assign dec_inst  = dec_valid ? foq_inst[front] : 32'h0;
  assign dec_pc    = dec_valid ? foq_pc[front]   : 32'h0;
  assign dec_pred  = dec_valid && foq_pred[front];
  assign dec_len   = dec_valid && foq_len[front];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        icache_req, icache_valid;
  logic [31:0] icache_addr, icache_data;
  logic        branch, inst_length, foq_full;
  logic [31:0] imm, pc_out;
  logic        need_branch, predict_fail, jalr_done;
  logic [31:0] branch_addr, fail_addr, jalr_addr;
  logic        dec_valid, dec_ready, dec_pred, dec_len;
  logic [31:0] dec_inst, dec_pc;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic        len;
  } ent_t;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] ADDI  = 32'h00000013;
  localparam logic [31:0] BEQ8  = 32'h00208463;
  localparam logic [31:0] JAL14 = 32'h00E0006F;
  localparam logic [31:0] JALR  = 32'h00008067;

  fetch_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_data(icache_data),
    .branch(branch), .imm(imm), .inst_length(inst_length), .pc_out(pc_out),
    .foq_full(foq_full), .need_branch(need_branch), .branch_addr(branch_addr),
    .predict_fail(predict_fail), .fail_addr(fail_addr),
    .jalr_done(jalr_done), .jalr_addr(jalr_addr),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_pred(dec_pred), .dec_len(dec_len)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for a request, answer it one cycle later, check predecode, record expected FOQ entry.
  task automatic serve_chk(input logic [31:0] addr, input logic [31:0] data, input logic nb,
                           input logic [31:0] baddr, input logic eb, input logic [31:0] eimm,
                           input logic elen);
    int   n = 0;
    ent_t e;
    #1;
    while (!icache_req && n < 20) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    check_eq("req", icache_req, 1);
    check_eq("icache_addr", icache_addr, addr);
    @(negedge clk_in);
    icache_valid = 1'b1;
    icache_data  = data;
    need_branch  = nb;
    branch_addr  = baddr;
    #1;
    check_eq("branch", branch, eb);
    check_eq("imm", imm, eimm);
    check_eq("inst_length", inst_length, elen);
    check_eq("pc_out", pc_out, addr);
    e.inst = elen ? data : {16'h0, data[15:0]};
    e.pc   = addr;
    e.pred = nb & eb;
    e.len  = elen;
    sb.push_back(e);
    @(negedge clk_in);
    icache_valid = 1'b0;
    icache_data  = 32'h0;
    need_branch  = 1'b0;
    branch_addr  = 32'h0;
  endtask

  task automatic pop_check();
    ent_t e;
    #1;
    e = sb.pop_front();
    check_eq("dec_valid", dec_valid, 1);
    check_eq("dec_inst", dec_inst, e.inst);
    check_eq("dec_pc", dec_pc, e.pc);
    check_eq("dec_pred", dec_pred, e.pred);
    check_eq("dec_len", dec_len, e.len);
    dec_ready = 1'b1;
    @(negedge clk_in);
    dec_ready = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) pop_check();
    #1;
    check_eq("drained", dec_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    icache_valid = 1'b0; icache_data = 32'h0;
    need_branch = 1'b0; branch_addr = 32'h0;
    predict_fail = 1'b0; fail_addr = 32'h0;
    jalr_done = 1'b0; jalr_addr = 32'h0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    check_eq("rst_req", icache_req, 0);
    check_eq("rst_addr", icache_addr, 32'h0);
    check_eq("rst_dec_valid", dec_valid, 0);
    check_eq("rst_full", foq_full, 0);
    check_eq("rst_branch", branch, 0);
    rst_in = 1'b1;

    // Sequential 32-bit, compressed with junk upper half, JAL
    serve_chk(32'h00, ADDI, 0, 0, 0, 0, 1);
    serve_chk(32'h04, ADDI, 0, 0, 0, 0, 1);
    serve_chk(32'h08, ADDI, 0, 0, 0, 0, 1);
    serve_chk(32'h0C, ADDI, 0, 0, 0, 0, 1);
    serve_chk(32'h10, 32'hABCD0001, 0, 0, 0, 0, 0);
    serve_chk(32'h12, JAL14, 0, 0, 0, 32'h0E, 1);
    drain();

    // BEQ taken, C.BEQZ negative offset, C.J, JALR
    serve_chk(32'h20, BEQ8, 1, 32'h28, 1, 32'h8, 1);
    serve_chk(32'h28, 32'h1234DC7D, 0, 32'h2A, 1, 32'hFFFFFFFE, 0);
    serve_chk(32'h2A, 32'h0000A819, 0, 0, 0, 32'h16, 0);
    serve_chk(32'h40, JALR, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("jalr_wait_req", icache_req, 0);
      @(negedge clk_in);
    end
    jalr_done = 1'b1;
    jalr_addr = 32'h100;
    @(negedge clk_in);
    jalr_done = 1'b0;
    drain();

    // Fill the FOQ, pop one, exactly one more fetch
    for (int i = 0; i < 8; i++) serve_chk(32'h100 + 32'(4 * i), ADDI, 0, 0, 0, 0, 1);
    #1;
    check_eq("full", foq_full, 1);
    check_eq("full_req", icache_req, 0);
    @(negedge clk_in);
    #1;
    check_eq("full_req2", icache_req, 0);
    pop_check();
    serve_chk(32'h120, ADDI, 0, 0, 0, 0, 1);
    #1;
    check_eq("refull", foq_full, 1);
    check_eq("refull_req", icache_req, 0);
    drain();

    // Mispredict while waiting: flush, drop the stale response, restart at fail_addr
    serve_chk(32'h124, ADDI, 0, 0, 0, 0, 1);
    @(negedge clk_in);
    #1;
    check_eq("pf_wait_addr", icache_addr, 32'h128);
    predict_fail = 1'b1;
    fail_addr    = 32'h200;
    @(negedge clk_in);
    predict_fail = 1'b0;
    #1;
    check_eq("pf_flush", dec_valid, 0);
    check_eq("pf_drop_req", icache_req, 0);
    sb.delete();
    icache_valid = 1'b1;
    icache_data  = ADDI;
    @(negedge clk_in);
    icache_valid = 1'b0;
    #1;
    check_eq("pf_dropped", dec_valid, 0);
    check_eq("pf_req", icache_req, 1);
    check_eq("pf_addr", icache_addr, 32'h200);

    // Mispredict with the response in the same cycle
    @(negedge clk_in);
    icache_valid = 1'b1;
    icache_data  = BEQ8;
    need_branch  = 1'b1;
    branch_addr  = 32'h28;
    predict_fail = 1'b1;
    fail_addr    = 32'h200;
    #1;
    check_eq("pf2_branch", branch, 0);
    @(negedge clk_in);
    icache_valid = 1'b0;
    need_branch  = 1'b0;
    predict_fail = 1'b0;
    #1;
    check_eq("pf2_nopush", dec_valid, 0);
    check_eq("pf2_req", icache_req, 1);
    check_eq("pf2_addr", icache_addr, 32'h200);

    // Freeze: response held across rdy_in low is taken only once rdy_in returns
    @(negedge clk_in);
    rdy_in       = 1'b0;
    icache_valid = 1'b1;
    icache_data  = 32'h00000001;
    #1;
    check_eq("frz_req", icache_req, 0);
    @(negedge clk_in);
    #1;
    check_eq("frz_nopush", dec_valid, 0);
    rdy_in = 1'b1;
    #1;
    check_eq("frz_len", inst_length, 0);
    @(negedge clk_in);
    icache_valid = 1'b0;
    #1;
    check_eq("frz_push", dec_valid, 1);
    check_eq("frz_dec_pc", dec_pc, 32'h200);
    check_eq("frz_dec_inst", dec_inst, 32'h1);
    check_eq("frz_next_addr", icache_addr, 32'h202);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage directly upstream of the branch predictor.
- Holds the PC, issues halfword-aligned fetches to the icache, and predecodes each RV32IC instruction into branch / imm / length for the predictor.
- Steers the next PC from the predictor's decision, or the JAL target, or the resolved JALR target, or the mispredict redirect.
- Buffers fetched instructions in the fetch output queue (FOQ) feeding the decoder.

Parameters:
FOQ_SIZE, 8, FOQ depth in entries (power of two)
FOQ_SIZE_W, 3, log2(FOQ_SIZE)
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  clock, all state updates on posedge
rst_in  input  1  synchronous, active-low reset
rdy_in  input  1  global ready; low = freeze all state, no requests, no pushes
icache_req  output  1  fetch request, held until icache_valid
icache_addr  output  32  fetch address (halfword aligned) = pc
icache_valid  input  1  response strobe for the outstanding request
icache_data  input  32  instruction bits at icache_addr (low halfword first)
branch  output  1  predecoded conditional branch this cycle, to predictor
imm  output  32  sign-extended branch/jump offset, to predictor
inst_length  output  1  1 = 32-bit instruction, 0 = 16-bit compressed
pc_out  output  32  PC of the instruction being pushed
foq_full  output  1  FOQ count == FOQ_SIZE
need_branch  input  1  predictor: predicted taken (same cycle as branch)
branch_addr  input  32  predictor: next PC for the branch
predict_fail  input  1  predictor: mispredict, redirect now
fail_addr  input  32  redirect target
jalr_done  input  1  JALR target resolved
jalr_addr  input  32  resolved JALR target
dec_valid  output  1  FOQ non-empty
dec_ready  input  1  decoder pops head when dec_valid && dec_ready
dec_inst  output  32  head instruction (upper 16 bits zero if compressed)
dec_pc  output  32  head PC
dec_pred  output  1  head predicted-taken bit
dec_len  output  1  head inst_length

Behaviour:
- Reset (rst_in==0 at posedge):
  - pc=RESET_PC, state=FETCH, FOQ empty (front=rear=count=0, entries zero).
  - All outputs 0 except icache_addr=RESET_PC.
- States:
  - FETCH: icache_req=1 iff count<FOQ_SIZE; on that edge go to WAIT.
  - WAIT: icache_req=1; on icache_valid, predecode and push (below).
  - JALR_WAIT: no request; on jalr_done, pc<=jalr_addr and go to FETCH.
  - DROP: no request; discard next icache_valid, then go to FETCH.
- Only one request is outstanding at a time, so FOQ cannot fill between issue and return. branch is still gated with !foq_full.
- Predecode, combinational on icache_data (d) in WAIT && icache_valid:
  - inst_length = (d[1:0]==2'b11).
  - B-type (opcode 1100011): branch=1, imm={{20{d[31]}},d[7],d[30:25],d[11:8],1'b0}.
  - C.BEQZ/C.BNEZ (d[1:0]=01, d[15:13]=110/111): branch=1, imm={{24{d[12]}},d[6:5],d[2],d[11:10],d[4:3],1'b0}.
  - JAL: imm={{12{d[31]}},d[19:12],d[20],d[30:21],1'b0}.
  - C.J/C.JAL (quadrant 01, funct3 101/001): imm={{21{d[12]}},d[8],d[10:9],d[6],d[7],d[2],d[11],d[5:3],1'b0}.
  - JALR (opcode 1100111); C.JR/C.JALR (quadrant 10, funct3 100, rs1!=0, rs2==0).
  - imm=0 for all other instructions. pc_out=pc.
- Push on the accept edge, writing {d masked to length, pc, need_branch&branch, inst_length} at rear. Next state and pc:
  - branch: pc<=branch_addr; FETCH.
  - JAL/C.J/C.JAL: pc<=pc+imm; FETCH.
  - JALR/C.JR/C.JALR: go to JALR_WAIT (pc held).
  - else: pc<=pc+(inst_length?4:2); FETCH.
- Pointers wrap modulo FOQ_SIZE.
- Simultaneous push and pop keeps count unchanged. dec_* are driven from the head, and are zero when empty.
- predict_fail (priority over everything except reset):
  - pc<=fail_addr; FOQ cleared (front=rear=count=0).
  - The same-cycle icache response and any same-cycle push are discarded; branch forced 0.
  - State: if in WAIT without icache_valid, go to DROP; otherwise go to FETCH.
  - A same-cycle jalr_done is ignored.
- rdy_in==0: no state change; icache_req=0; branch=0. A response arriving while frozen is not accepted; the icache holds icache_valid until rdy_in returns.
- Adder widths: 32-bit, wrap modulo 2^32.

Test Plan:
- Reset to 0, icache returns 32'h00000013 (addi) at pc 0,4,8 -> three pushes, pc sequence 0→4→8→C, inst_length=1, branch=0.
- C.NOP 16'h0001 at pc 0x10 -> inst_length=0, next pc 0x12, dec_inst=32'h00000001.
- BEQ 32'h00208463 at 0x20 (offset +8), need_branch=1, branch_addr=0x28 -> branch=1, imm=8, next fetch at 0x28, dec_pred=1.
- JALR at 0x40 -> no request until jalr_done with jalr_addr=0x100 -> next icache_addr=0x100.
- dec_ready=0, 8 pushes -> foq_full=1, icache_req=0. One pop -> exactly one more fetch, wrap rear 7→0.
- predict_fail with fail_addr=0x200 while in WAIT -> FOQ empty, next response dropped, then request at 0x200. Repeat with icache_valid in the same cycle -> no push, immediate request at 0x200.
